seg7_scan_decoder: RTL

Recovers hexadecimal digit values from a time-multiplexed, active-low 7-segment display bus (digit-select strobe plus shared segment lines) and assembles them into a word. It is the inverse of the hex-to-segment encoder: it maps each segment pattern back to a nibble. A per-digit stability filter rejects scan ghosting. Complete frames go out through a valid/ready handshake. It sits on the board loopback and debug path, where it lets the bench or a soft monitor read back what the display is actually showing.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_nibble.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit 0 = a .. bit 6 = g)
// and the code/nibble types used by both the encoder and the scan decoder.
package seg7_pkg;

  typedef logic [6:0] seg_code_t;
  typedef logic [3:0] nibble_t;

  localparam seg_code_t SEG_0    = 7'h40;
  localparam seg_code_t SEG_1    = 7'h79;
  localparam seg_code_t SEG_2    = 7'h24;
  localparam seg_code_t SEG_3    = 7'h30;
  localparam seg_code_t SEG_4    = 7'h19;
  localparam seg_code_t SEG_5    = 7'h12;
  localparam seg_code_t SEG_6    = 7'h02;
  localparam seg_code_t SEG_7    = 7'h78;
  localparam seg_code_t SEG_8    = 7'h00;
  localparam seg_code_t SEG_9    = 7'h10;
  localparam seg_code_t SEG_A    = 7'h08;
  localparam seg_code_t SEG_B    = 7'h03;
  localparam seg_code_t SEG_C    = 7'h46;
  localparam seg_code_t SEG_D    = 7'h21;
  localparam seg_code_t SEG_E    = 7'h06;
  localparam seg_code_t SEG_F    = 7'h0E;
  localparam seg_code_t SEG_DASH = 7'h3F;

endpackage

// File: rtl/seg7_to_nibble.sv
// Inverse segment decoder: maps an active-low 7-segment code back to its hex
// nibble. Unrecognised codes (dash included) give nibble 0 with valid low.
module seg7_to_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] code,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table lookup of the sixteen hex glyphs; anything else is flagged invalid
  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (code)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scan-bus readback: samples a multiplexed active-low 7-segment bus, accepts a
// digit once it has been stable for STABLE_CNT samples, assembles a frame of
// NUM_DIGITS nibbles and presents it on a valid/ready handshake.
// Optional build macro SEG7_DEC_ERRCNT_EN adds o_err_cnt, a saturating count
// of digit captures carrying unrecognised codes.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [6:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_dig_sel,
  input  logic                    i_ready,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic                    o_valid,
  output logic                    o_err,
  output logic                    o_ovf
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [7:0]              o_err_cnt
`endif
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CNT);

  logic [6:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   sel_reg;
  logic [7:0]              stab_cnt_reg;
  logic [7:0]              stab_cnt_next;
  logic                    sel_onehot;
  logic                    same_sample;
  logic                    capture;
  logic                    dec_valid;
  nibble_t                 dec_nibble;
  logic [4*NUM_DIGITS-1:0] slot_vec;
  logic [NUM_DIGITS-1:0]   err_vec;
  logic [NUM_DIGITS-1:0]   mask_vec;
  logic                    frame_full;

  // Decode the previous sample; at a capture edge it equals the current input
  seg7_to_nibble u_dec (
    .code   (seg_reg),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  // Stability filter: blanking/multi-select clears, a repeat counts up, a change restarts at 1
  always_comb begin
    sel_onehot    = $onehot(i_dig_sel);
    same_sample   = (i_dig_sel == sel_reg) && (i_seg == seg_reg);
    stab_cnt_next = 8'd0;
    if (sel_onehot) begin
      if (same_sample)
        stab_cnt_next = (stab_cnt_reg == STAB_MAX) ? stab_cnt_reg : stab_cnt_reg + 8'd1;
      else
        stab_cnt_next = 8'd1;
    end
    capture    = sel_onehot && same_sample && (stab_cnt_reg == STAB_MAX - 8'd1);
    frame_full = &mask_vec;
  end

  // Previous-cycle sample registers and the stability counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_reg      <= 7'h7F;
      sel_reg      <= '0;
      stab_cnt_reg <= 8'd0;
    end else begin
      seg_reg      <= i_seg;
      sel_reg      <= i_dig_sel;
      stab_cnt_reg <= stab_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      logic [3:0] nib_reg;
      logic       err_reg;
      logic       got_reg;

      // Slot is emptied when the full frame is taken or dropped, otherwise written on its capture
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          nib_reg <= 4'h0;
          err_reg <= 1'b0;
          got_reg <= 1'b0;
        end else if (frame_full) begin
          err_reg <= 1'b0;
          got_reg <= 1'b0;
        end else if (capture && sel_reg[gi]) begin
          nib_reg <= dec_nibble;
          err_reg <= ~dec_valid;
          got_reg <= 1'b1;
        end
      end

      assign slot_vec[4*gi +: 4] = nib_reg;
      assign err_vec[gi]         = err_reg;
      assign mask_vec[gi]        = got_reg;
    end
  endgenerate

  // Output stage: load a complete frame unless the previous one is still unaccepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_value <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_ovf <= 1'b0;
      if (frame_full) begin
        if (!o_valid || i_ready) begin
          o_value <= slot_vec;
          o_err   <= |err_vec;
          o_valid <= 1'b1;
        end else begin
          o_ovf <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  // Saturating count of captures that carried an unrecognised code
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_err_cnt <= 8'd0;
    else if (capture && !dec_valid && (o_err_cnt != 8'hFF))
      o_err_cnt <= o_err_cnt + 8'd1;
  end
`endif

endmodule
